// File: rtl/data_path_pkg.sv
// Shared definitions for the single-bus datapath: bus width and ALU operation encodings.
package data_path_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpAnd  = 5'b00010;
  localparam logic [4:0] OpOr   = 5'b00011;
  localparam logic [4:0] OpShr  = 5'b00100;
  localparam logic [4:0] OpShra = 5'b00101;
  localparam logic [4:0] OpShl  = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpMul  = 5'b01001;
  localparam logic [4:0] OpDiv  = 5'b01010;
  localparam logic [4:0] OpNeg  = 5'b01011;
  localparam logic [4:0] OpNot  = 5'b01100;
  localparam logic [4:0] OpInc  = 5'b01101;

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A comes from RY, B from the bus; produces a 64-bit {hi, lo} result.
module data_path_alu
  import data_path_pkg::*;
(
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [4:0]         op,
  output logic [2*WIDTH-1:0] result
);

  logic [4:0]         sh;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] rot_r;
  logic [2*WIDTH-1:0] rot_l;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   sra;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  assign sh    = b[4:0];
  // Sign-extend both operands so the low 64 bits of the product are the signed product.
  assign prod  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign rot_r = {a, a} >> sh;
  assign rot_l = {a, a} << sh;
  assign sra   = $signed(a) >>> sh;
  assign quot  = $signed(a) / $signed(b);
  assign rem   = $signed(a) % $signed(b);

  always_comb begin
    hi = '0;
    lo = b;
    case (op)
      OpAdd:  lo = a + b;
      OpSub:  lo = a - b;
      OpAnd:  lo = a & b;
      OpOr:   lo = a | b;
      OpShr:  lo = a >> sh;
      OpShra: lo = sra;
      OpShl:  lo = a << sh;
      OpRor:  lo = rot_r[WIDTH-1:0];
      OpRol:  lo = rot_l[2*WIDTH-1:WIDTH];
      OpMul:  {hi, lo} = prod;
      OpDiv: begin
        if (b == '0) begin
          hi = a;
          lo = '1;
        end else begin
          hi = rem;
          lo = quot;
        end
      end
      OpNeg:  lo = -b;
      OpNot:  lo = ~b;
      OpInc:  lo = b + 1'b1;
      default: lo = b;
    endcase
  end

  assign result = {hi, lo};

endmodule

// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: register file, special registers, priority bus mux and ALU.
module data_path
  import data_path_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [4:0]       ops,
  input  logic RAout, R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout, MDRout, PORTout,
  input  logic RAin, R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic RYin, RZin, PCin, IRin, HIin, LOin, MDRin, PORTin,
  input  logic             Read,
  output logic [WIDTH-1:0] BusMuxOut
);

  logic [WIDTH-1:0]   r_q [16];
  logic [WIDTH-1:0]   ra_q, ry_q, pc_q, ir_q, hi_q, lo_q, mdr_q, port_q;
  logic [2*WIDTH-1:0] rz_q;
  logic [2*WIDTH-1:0] alu_result;
  logic [15:0]        r_out, r_in;
  logic [WIDTH-1:0]   r_bus, bus;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // Lowest-numbered general register wins when several are strobed.
  always_comb begin
    r_bus = '0;
    for (int k = 15; k >= 0; k--) begin
      if (r_out[k]) r_bus = r_q[k];
    end
  end

  always_comb begin
    if (MDRout)       bus = mdr_q;
    else if (RZLOout) bus = rz_q[WIDTH-1:0];
    else if (RZHIout) bus = rz_q[2*WIDTH-1:WIDTH];
    else if (PCout)   bus = pc_q;
    else if (IRout)   bus = ir_q;
    else if (HIout)   bus = hi_q;
    else if (LOout)   bus = lo_q;
    else if (RYout)   bus = ry_q;
    else if (PORTout) bus = port_q;
    else if (RAout)   bus = ra_q;
    else              bus = r_bus;
  end

  assign BusMuxOut = bus;

  data_path_alu u_alu (
    .a      (ry_q),
    .b      (bus),
    .op     (ops),
    .result (alu_result)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int k = 0; k < 16; k++) r_q[k] <= '0;
      ra_q   <= '0;
      ry_q   <= '0;
      rz_q   <= '0;
      pc_q   <= '0;
      ir_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      mdr_q  <= '0;
      port_q <= '0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (r_in[k]) r_q[k] <= bus;
      end
      if (RAin)   ra_q   <= bus;
      if (RYin)   ry_q   <= bus;
      if (RZin)   rz_q   <= alu_result;
      if (PCin)   pc_q   <= bus;
      if (IRin)   ir_q   <= bus;
      if (HIin)   hi_q   <= bus;
      if (LOin)   lo_q   <= bus;
      if (MDRin)  mdr_q  <= Read ? Mdatain : bus;
      if (PORTin) port_q <= bus;
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: a register-transfer model predicts the bus every cycle.
module tb_data_path;
  import data_path_pkg::*;

  // Out-strobe bit indices (R0..R15 occupy 1..16).
  localparam int ORa = 0, OR0 = 1, ORy = 17, ORzhi = 18, ORzlo = 19, OPc = 20, OIr = 21;
  localparam int OHi = 22, OLo = 23, OMdr = 24, OPort = 25;
  // In-strobe bit indices (R0..R15 occupy 1..16).
  localparam int IRa = 0, IR0 = 1, IRy = 17, IRz = 18, IPc = 19, IIr = 20, IHi = 21;
  localparam int ILo = 22, IMdr = 23, IPort = 24;

  logic        clock, clear, rd;
  logic [31:0] md;
  logic [4:0]  op_s;
  logic [25:0] out_s;
  logic [24:0] in_s;
  logic [31:0] bus_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [31:0] m_r [16];
  logic [31:0] m_ra, m_ry, m_pc, m_ir, m_hi, m_lo, m_mdr, m_port;
  logic [63:0] m_rz;

  data_path dut (
    .clock(clock), .clear(clear), .Mdatain(md), .ops(op_s),
    .RAout(out_s[ORa]), .R0out(out_s[OR0]), .R1out(out_s[OR0+1]), .R2out(out_s[OR0+2]),
    .R3out(out_s[OR0+3]), .R4out(out_s[OR0+4]), .R5out(out_s[OR0+5]), .R6out(out_s[OR0+6]),
    .R7out(out_s[OR0+7]), .R8out(out_s[OR0+8]), .R9out(out_s[OR0+9]),
    .R10out(out_s[OR0+10]), .R11out(out_s[OR0+11]), .R12out(out_s[OR0+12]),
    .R13out(out_s[OR0+13]), .R14out(out_s[OR0+14]), .R15out(out_s[OR0+15]),
    .RYout(out_s[ORy]), .RZHIout(out_s[ORzhi]), .RZLOout(out_s[ORzlo]), .PCout(out_s[OPc]),
    .IRout(out_s[OIr]), .HIout(out_s[OHi]), .LOout(out_s[OLo]), .MDRout(out_s[OMdr]),
    .PORTout(out_s[OPort]),
    .RAin(in_s[IRa]), .R0in(in_s[IR0]), .R1in(in_s[IR0+1]), .R2in(in_s[IR0+2]),
    .R3in(in_s[IR0+3]), .R4in(in_s[IR0+4]), .R5in(in_s[IR0+5]), .R6in(in_s[IR0+6]),
    .R7in(in_s[IR0+7]), .R8in(in_s[IR0+8]), .R9in(in_s[IR0+9]), .R10in(in_s[IR0+10]),
    .R11in(in_s[IR0+11]), .R12in(in_s[IR0+12]), .R13in(in_s[IR0+13]),
    .R14in(in_s[IR0+14]), .R15in(in_s[IR0+15]),
    .RYin(in_s[IRy]), .RZin(in_s[IRz]), .PCin(in_s[IPc]), .IRin(in_s[IIr]),
    .HIin(in_s[IHi]), .LOin(in_s[ILo]), .MDRin(in_s[IMdr]), .PORTin(in_s[IPort]),
    .Read(rd), .BusMuxOut(bus_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [25:0] ob(input int k);
    return 26'(1) << k;
  endfunction

  function automatic logic [24:0] ib(input int k);
    return 25'(1) << k;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] src(input int k);
    if (k >= OR0 && k < OR0 + 16) return m_r[k-OR0];
    case (k)
      ORa:   return m_ra;
      ORy:   return m_ry;
      ORzhi: return m_rz[63:32];
      ORzlo: return m_rz[31:0];
      OPc:   return m_pc;
      OIr:   return m_ir;
      OHi:   return m_hi;
      OLo:   return m_lo;
      OMdr:  return m_mdr;
      default: return m_port;
    endcase
  endfunction

  function automatic logic [31:0] model_bus();
    int prio[26];
    prio[0] = OMdr; prio[1] = ORzlo; prio[2] = ORzhi; prio[3] = OPc; prio[4] = OIr;
    prio[5] = OHi; prio[6] = OLo; prio[7] = ORy; prio[8] = OPort; prio[9] = ORa;
    for (int k = 0; k < 16; k++) prio[10+k] = OR0 + k;
    for (int k = 0; k < 26; k++) begin
      if (out_s[prio[k]]) return src(prio[k]);
    end
    return 32'h0;
  endfunction

  function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
    int          sa, sb, s;
    logic [63:0] dbl;
    logic [31:0] lo;
    sa = a;
    sb = b;
    s  = int'(b[4:0]);
    dbl = {a, a};
    case (op)
      OpAdd:  lo = a + b;
      OpSub:  lo = a - b;
      OpAnd:  lo = a & b;
      OpOr:   lo = a | b;
      OpShr:  lo = a >> s;
      OpShra: lo = sa >>> s;
      OpShl:  lo = a << s;
      OpRor:  begin dbl = dbl >> s; lo = dbl[31:0]; end
      OpRol:  begin dbl = dbl << s; lo = dbl[63:32]; end
      OpMul:  return longint'(sa) * longint'(sb);
      OpDiv:  begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      OpNeg:  lo = 32'h0 - b;
      OpNot:  lo = ~b;
      OpInc:  lo = b + 32'h1;
      default: lo = b;
    endcase
    return {32'h0, lo};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) m_r[k] = '0;
    m_ra = '0; m_ry = '0; m_rz = '0; m_pc = '0; m_ir = '0;
    m_hi = '0; m_lo = '0; m_mdr = '0; m_port = '0;
  endtask

  task automatic model_edge();
    logic [31:0] b;
    logic [63:0] z;
    b = model_bus();
    z = model_alu(m_ry, b, op_s);
    for (int k = 0; k < 16; k++) if (in_s[IR0+k]) m_r[k] = b;
    if (in_s[IRa])   m_ra   = b;
    if (in_s[IRy])   m_ry   = b;
    if (in_s[IRz])   m_rz   = z;
    if (in_s[IPc])   m_pc   = b;
    if (in_s[IIr])   m_ir   = b;
    if (in_s[IHi])   m_hi   = b;
    if (in_s[ILo])   m_lo   = b;
    if (in_s[IMdr])  m_mdr  = rd ? md : b;
    if (in_s[IPort]) m_port = b;
  endtask

  // Continuous comparison of the bus against the model.
  always @(negedge clock) begin
    if (clear === 1'b1) check("bus_model", bus_o, model_bus());
  end

  // One register-transfer cycle; optional literal check of the bus mid-cycle.
  task automatic tick(input string name, input logic [25:0] o, input logic [24:0] i,
                      input logic [4:0] op, input logic r, input logic [31:0] d,
                      input bit chk, input logic [31:0] exp);
    out_s = o; in_s = i; op_s = op; rd = r; md = d;
    @(negedge clock);
    if (chk) check(name, bus_o, exp);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    tick("", '0, ib(IMdr), OpAdd, 1'b1, v, 1'b0, 32'h0);
  endtask

  logic [4:0]  t_op  [12];
  logic [31:0] t_exp [12];

  initial begin
    t_op = '{OpShr, OpShra, OpShl, OpRor, OpRol, OpAdd, OpAnd, OpOr, OpNeg, OpNot, OpInc,
             5'h1F};
    t_exp = '{32'h4000_0000, 32'hC000_0000, 32'h0000_0002, 32'hC000_0000, 32'h0000_0003,
              32'h8000_0002, 32'h0000_0001, 32'h8000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
              32'h0000_0002, 32'h0000_0001};
    clear = 1'b0; out_s = '0; in_s = '0; op_s = '0; rd = 1'b0; md = '0;
    model_clear();
    #12 clear = 1'b1;
    @(posedge clock); #1;

    // Preload some registers, then reset asynchronously mid-cycle.
    load_mdr(32'h1234_5678);
    tick("mdr_pre", ob(OMdr), ib(IR0+3) | ib(IPort) | ib(IPc), OpAdd, 1'b0, '0, 1'b1,
         32'h1234_5678);
    tick("r3_pre", ob(OR0+3), ib(IRy), OpAdd, 1'b0, '0, 1'b1, 32'h1234_5678);
    #1 clear = 1'b0;
    model_clear();
    for (int k = 0; k < 26; k++) begin
      out_s = ob(k);
      #1 check("reset_reg", bus_o, 32'h0);
    end
    out_s = '0; in_s = '0;
    #1 check("reset_idle_bus", bus_o, 32'h0);
    @(negedge clock) clear = 1'b1;
    @(posedge clock); #1;

    // Instruction fetch
    tick("fetch_pc", ob(OPc), ib(IRz), OpInc, 1'b0, '0, 1'b1, 32'h0);
    tick("fetch_rz", ob(ORzlo), ib(IPc) | ib(IMdr), OpAdd, 1'b1, 32'h0000_DEAD, 1'b1,
         32'h1);
    tick("fetch_pc1", ob(OPc), '0, OpAdd, 1'b0, '0, 1'b1, 32'h1);
    tick("fetch_mdr", ob(OMdr), ib(IIr), OpAdd, 1'b0, '0, 1'b1, 32'h0000_DEAD);
    tick("fetch_ir", ob(OIr), '0, OpAdd, 1'b0, '0, 1'b1, 32'h0000_DEAD);

    // Store/load path
    load_mdr(32'h0000_BEEF);
    tick("mdr_beef", ob(OMdr), ib(IR0+2), OpAdd, 1'b0, '0, 1'b1, 32'h0000_BEEF);
    load_mdr(32'h0000_1111);
    tick("r2_beef", ob(OR0+2), ib(IMdr), OpAdd, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0000_BEEF);
    tick("mdr_from_bus", ob(OMdr), '0, OpAdd, 1'b0, '0, 1'b1, 32'h0000_BEEF);

    // Add / subtract
    load_mdr(32'd7);
    tick("ry7", ob(OMdr), ib(IRy), OpAdd, 1'b0, '0, 1'b0, '0);
    load_mdr(32'd5);
    tick("add_b", ob(OMdr), ib(IRz), OpAdd, 1'b0, '0, 1'b1, 32'd5);
    tick("add12", ob(ORzlo), '0, OpAdd, 1'b0, '0, 1'b1, 32'd12);
    tick("sub_b", ob(OMdr), ib(IRz), OpSub, 1'b0, '0, 1'b0, '0);
    tick("sub2", ob(ORzlo), '0, OpAdd, 1'b0, '0, 1'b1, 32'd2);

    // Multiply, with RZ halves moved into HI/LO
    load_mdr(32'hFFFF_FFFA);
    tick("", ob(OMdr), ib(IRy), OpAdd, 1'b0, '0, 1'b0, '0);
    load_mdr(32'd3);
    tick("", ob(OMdr), ib(IRz), OpMul, 1'b0, '0, 1'b0, '0);
    tick("mul_hi", ob(ORzhi), ib(IHi), OpAdd, 1'b0, '0, 1'b1, 32'hFFFF_FFFF);
    tick("mul_lo", ob(ORzlo), ib(ILo), OpAdd, 1'b0, '0, 1'b1, 32'hFFFF_FFEE);
    tick("hi_reg", ob(OHi), '0, OpAdd, 1'b0, '0, 1'b1, 32'hFFFF_FFFF);
    tick("lo_reg", ob(OLo), '0, OpAdd, 1'b0, '0, 1'b1, 32'hFFFF_FFEE);

    // Divide, including divide-by-zero
    load_mdr(32'd7);
    tick("", ob(OMdr), ib(IRy), OpAdd, 1'b0, '0, 1'b0, '0);
    load_mdr(32'd2);
    tick("", ob(OMdr), ib(IRz), OpDiv, 1'b0, '0, 1'b0, '0);
    tick("div_lo", ob(ORzlo), '0, OpAdd, 1'b0, '0, 1'b1, 32'd3);
    tick("div_hi", ob(ORzhi), '0, OpAdd, 1'b0, '0, 1'b1, 32'd1);
    tick("", '0, ib(IRz), OpDiv, 1'b0, '0, 1'b0, '0);
    tick("div0_lo", ob(ORzlo), '0, OpAdd, 1'b0, '0, 1'b1, 32'hFFFF_FFFF);
    tick("div0_hi", ob(ORzhi), '0, OpAdd, 1'b0, '0, 1'b1, 32'd7);

    // Shifts, rotates and logic ops with A = 8000_0001, B = 1
    load_mdr(32'h8000_0001);
    tick("", ob(OMdr), ib(IRy), OpAdd, 1'b0, '0, 1'b0, '0);
    load_mdr(32'd1);
    for (int k = 0; k < 12; k++) begin
      tick("", ob(OMdr), ib(IRz), t_op[k], 1'b0, '0, 1'b0, '0);
      tick($sformatf("alu_op_%0d", t_op[k]), ob(ORzlo), '0, OpAdd, 1'b0, '0, 1'b1, t_exp[k]);
    end

    // Bus priority with two drivers
    load_mdr(32'hA5A5_A5A5);
    tick("", ob(OMdr), ib(IR0+1), OpAdd, 1'b0, '0, 1'b0, '0);
    load_mdr(32'h0000_005A);
    tick("prio_mdr_r1", ob(OMdr) | ob(OR0+1), '0, OpAdd, 1'b0, '0, 1'b1, 32'h0000_005A);
    tick("prio_r1_r2", ob(OR0+1) | ob(OR0+2), '0, OpAdd, 1'b0, '0, 1'b1, 32'hA5A5_A5A5);
    tick("prio_pc_port", ob(OPc) | ob(OPort), '0, OpAdd, 1'b0, '0, 1'b1, 32'h1);
    // Same-cycle drive and load of one register keeps the pre-edge value
    tick("", ob(OR0+1), ib(IR0+1), OpAdd, 1'b0, '0, 1'b0, '0);
    tick("self_load", ob(OR0+1), '0, OpAdd, 1'b0, '0, 1'b1, 32'hA5A5_A5A5);

    tick("idle_end", '0, '0, OpAdd, 1'b0, '0, 1'b1, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Single-bus 32-bit CPU datapath: 16 general registers, special registers (RA, RY, RZ, PC, IR, HI, LO, MDR, PORT), one-hot bus multiplexer and ALU.
- A control unit, or a bench acting as one, asserts one-hot out/in strobes each cycle to move data over the shared bus.
- Memory data enters only through MDR via Mdatain.

Parameters:
- WIDTH, 32, data/bus width. All registers except RZ are WIDTH wide; RZ is 2*WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-low reset.
- Mdatain  input  32  memory read data into MDR.
- ops  input  5  ALU operation select.
- RAout, R0out..R15out, RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout, MDRout, PORTout  input  1 each  bus drive strobes, in this positional order.
- RAin, R0in..R15in, RYin, RZin, PCin, IRin, HIin, LOin, MDRin, PORTin  input  1 each  register load enables, in this positional order.
- Read  input  1  MDR source select: 1 = Mdatain, 0 = bus.
- BusMuxOut  output  32  current bus value (observation); appended last.

Behaviour:
- Reset: clear low clears every register (R0..R15, RA, RY, RZ[63:0], PC, IR, HI, LO, MDR, PORT) to 0 immediately, independent of clock.
- Registers: each loads on rising clock when its *in strobe = 1, otherwise holds.
  - Source is BusMuxOut, except MDR and RZ.
  - MDR loads Mdatain if Read = 1, else the bus.
  - RZ loads the 64-bit ALU result.
  - R0 is an ordinary register (no hardwired zero).
- Bus: combinational one-hot mux of the *out strobes.
  - RZHIout drives RZ[63:32]; RZLOout drives RZ[31:0].
  - No strobe asserted: bus = 0.
  - Multiple strobes asserted: fixed priority MDRout > RZLOout > RZHIout > PCout > IRout > HIout > LOout > RYout > PORTout > RAout > R0out..R15out (lowest index wins). The control unit must not rely on this.
- Same-cycle load: a register that is both driving and loading captures the pre-edge bus value.
- ALU: combinational. A = RY, B = bus; shift/rotate amount = B[4:0].
  - 00000 ADD: A+B
  - 00001 SUB: A-B
  - 00010 AND
  - 00011 OR
  - 00100 SHR: A logical right
  - 00101 SHRA: A arithmetic right
  - 00110 SHL
  - 00111 ROR: A rotate right
  - 01000 ROL
  - 01001 MUL: signed A*B, full 64 bits
  - 01010 DIV: signed; hi = A%B, lo = A/B
  - 01011 NEG: -B
  - 01100 NOT: ~B
  - 01101 INC: B+1 (PC increment)
  - others: pass B
- ALU result width: for all ops except MUL/DIV, result = {32'h0, lo}; carry/overflow discarded (mod 2^32).
- DIV by zero: lo = 32'hFFFFFFFF, hi = A. No exception raised.
- No internal state machine. Sequencing is entirely external, one register transfer per cycle.

Decomposition:
- Shared package: ALU op encodings (localparams for the 14 named ops) and WIDTH.
- One natural sub-module: alu (A, B, op -> 64-bit result).
- Registers and bus mux stay inline, or use a trivial reg32 cell with async active-low clear.

Test Plan:
- Reset: drive clear low mid-cycle with values loaded -> all registers 0 at once; BusMuxOut = 0 with no strobes.
- Instruction fetch:
  - PCout, RZin, ops = INC with PC = 0 -> RZ = 1.
  - Next cycle RZLOout, PCin, Read = 1, Mdatain = 32'h0000DEAD, MDRin -> PC = 1, MDR = 32'h0000DEAD.
  - Then MDRout, IRin -> IR = 32'h0000DEAD.
- Store/load path:
  - MDR = 32'h0000BEEF via Read; MDRout, R2in -> R2 = 32'h0000BEEF.
  - Read = 0, R2out, MDRin -> MDR takes the bus value.
- ALU arithmetic:
  - RY = 7, bus = 5, ADD -> RZ lo 12; SUB -> 2.
  - RY = -6, bus = 3, MUL -> RZ = 64'hFFFFFFFF_FFFFFFEE.
  - RY = 7, bus = 2, DIV -> lo 3, hi 1.
  - Bus = 0, DIV -> lo FFFFFFFF, hi 7.
- Shifts: RY = 32'h80000001, amount 1 -> SHR 40000000, SHRA C0000000, SHL 00000002, ROR C0000000, ROL 00000003.
- Bus/RZ halves:
  - After MUL, RZHIout and RZLOout each drive the correct half; HIin/LOin capture them.
  - MDRout and R1out both asserted -> bus = MDR (priority).
